// File: rtl/axi_slave_ram.sv
// AXI3 slave memory model: one outstanding read and one outstanding write,
// INCR/FIXED bursts (WRAP steps like INCR), byte strobes, word array aliased over 4 GiB.
module axi_slave_ram #(
   parameter int unsigned MEM_AW       = 14,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned DEPTH = 1 << MEM_AW;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned CNT_W = 4;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

   logic [31:0] mem [DEPTH];

   logic              live_q, live_d;

   rstate_e           rstate_q, rstate_d;
   logic [3:0]        rid_q, rid_d;
   logic [MEM_AW-1:0] ridx_q, ridx_d;
   logic [LEN_W-1:0]  rlen_q, rlen_d;
   logic [LEN_W-1:0]  rbeat_q, rbeat_d;
   logic              rfixed_q, rfixed_d;
   logic [CNT_W-1:0]  rwait_q, rwait_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              rlast_q, rlast_d;
   logic              arready_q, arready_d;

   wstate_e           wstate_q, wstate_d;
   logic [3:0]        bid_q, bid_d;
   logic [MEM_AW-1:0] widx_q, widx_d;
   logic [LEN_W-1:0]  wlen_q, wlen_d;
   logic [LEN_W-1:0]  wbeat_q, wbeat_d;
   logic              wfixed_q, wfixed_d;
   logic              werr_q, werr_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;

   logic [MEM_AW-1:0] ar_idx_c;
   logic [MEM_AW-1:0] aw_idx_c;
   logic [MEM_AW-1:0] r_step_c;
   logic [MEM_AW-1:0] w_step_c;
   logic [LEN_W-1:0]  rbeat_inc_c;
   logic              ar_hs_c;
   logic              aw_hs_c;
   logic              w_hs_c;
   logic              w_en_c;
   logic              unused_c;

   assign ar_idx_c    = araddr[MEM_AW+1:2];
   assign aw_idx_c    = awaddr[MEM_AW+1:2];
   assign r_step_c    = rfixed_q ? ridx_q : ridx_q + MEM_AW'(1);
   assign w_step_c    = wfixed_q ? widx_q : widx_q + MEM_AW'(1);
   assign rbeat_inc_c = rbeat_q + LEN_W'(1);
   assign ar_hs_c     = arvalid && arready_q;
   assign aw_hs_c     = awvalid && awready_q;
   assign w_hs_c      = wvalid && wready_q;
   assign w_en_c      = (wstate_q == W_DATA) && w_hs_c;

   // Size, write ID and the address bits outside the word index do not affect behaviour.
   assign unused_c = ^{arsize, awsize, wid, araddr[31:MEM_AW+2], araddr[1:0],
                       awaddr[31:MEM_AW+2], awaddr[1:0]};

   assign live_d = 1'b1;

   // Read channel next state; rdata loads from the array on entry to R_DATA and on each accepted non-final beat.
   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      ridx_d   = ridx_q;
      rlen_d   = rlen_q;
      rbeat_d  = rbeat_q;
      rfixed_d = rfixed_q;
      rwait_d  = rwait_q;
      rdata_d  = rdata_q;
      rlast_d  = rlast_q;
      unique case (rstate_q)
         R_IDLE: begin
            if (ar_hs_c) begin
               rid_d    = arid;
               ridx_d   = ar_idx_c;
               rlen_d   = arlen;
               rfixed_d = (arburst == BURST_FIXED);
               rbeat_d  = '0;
               if (READ_LATENCY == 1) begin
                  rstate_d = R_DATA;
                  rdata_d  = mem[ar_idx_c];
                  rlast_d  = (arlen == LEN_W'(0));
               end else begin
                  rstate_d = R_WAIT;
                  rwait_d  = CNT_W'(READ_LATENCY - 2);
               end
            end
         end
         R_WAIT: begin
            if (rwait_q == '0) begin
               rstate_d = R_DATA;
               rdata_d  = mem[ridx_q];
               rlast_d  = (rlen_q == LEN_W'(0));
            end else begin
               rwait_d = rwait_q - CNT_W'(1);
            end
         end
         R_DATA: begin
            if (rready) begin
               if (rlast_q) begin
                  rstate_d = R_IDLE;
                  rlast_d  = 1'b0;
               end else begin
                  rbeat_d = rbeat_inc_c;
                  ridx_d  = r_step_c;
                  rdata_d = mem[r_step_c];
                  rlast_d = (rbeat_inc_c == rlen_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      rvalid_d  = (rstate_d == R_DATA);
      arready_d = live_d && (rstate_d == R_IDLE);
   end

   // Write channel next state; a missing or early wlast ends the burst with SLVERR.
   always_comb begin
      wstate_d = wstate_q;
      bid_d    = bid_q;
      widx_d   = widx_q;
      wlen_d   = wlen_q;
      wbeat_d  = wbeat_q;
      wfixed_d = wfixed_q;
      werr_d   = werr_q;
      unique case (wstate_q)
         W_IDLE: begin
            if (aw_hs_c) begin
               bid_d    = awid;
               widx_d   = aw_idx_c;
               wlen_d   = awlen;
               wfixed_d = (awburst == BURST_FIXED);
               wbeat_d  = '0;
               werr_d   = 1'b0;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs_c) begin
               widx_d  = w_step_c;
               wbeat_d = wbeat_q + LEN_W'(1);
               if (wlast) begin
                  werr_d   = (wbeat_q != wlen_q);
                  wstate_d = W_RESP;
               end else if (wbeat_q == wlen_q) begin
                  werr_d   = 1'b1;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
      awready_d = live_d && (wstate_d == W_IDLE);
      wready_d  = (wstate_d == W_DATA);
      bvalid_d  = (wstate_d == W_RESP);
      bresp_d   = ((wstate_d == W_RESP) && werr_d) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         live_q    <= 1'b0;
         rstate_q  <= R_IDLE;
         rid_q     <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rfixed_q  <= 1'b0;
         rwait_q   <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         arready_q <= 1'b0;
         wstate_q  <= W_IDLE;
         bid_q     <= '0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wfixed_q  <= 1'b0;
         werr_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         live_q    <= live_d;
         rstate_q  <= rstate_d;
         rid_q     <= rid_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rfixed_q  <= rfixed_d;
         rwait_q   <= rwait_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         arready_q <= arready_d;
         wstate_q  <= wstate_d;
         bid_q     <= bid_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wfixed_q  <= wfixed_d;
         werr_q    <= werr_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Storage is not reset; a same-edge rdata load sees the pre-write word.
   always_ff @(posedge clk) begin
      if (w_en_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign arready = arready_q;
   assign rid     = rid_q;
   assign rdata   = rdata_q;
   assign rresp   = RESP_OKAY;
   assign rlast   = rlast_q;
   assign rvalid  = rvalid_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;

endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
AXI3 slave (responder) memory model that terminates the master-side bus driven by cpu_axi_interface. It is used as the memory target in simulation and FPGA bring-up in place of the SoC RAM. It supports independent read and write channels with one outstanding transaction each, INCR/FIXED bursts, and byte strobes. Memory is a word-addressed register array aliased across the full 32-bit physical address space.

Parameters:
MEM_AW, 14, log2 of memory depth in 32-bit words; word index = addr[MEM_AW+1:2], upper bits ignored.
READ_LATENCY, 1, cycles from AR handshake to first rvalid; legal 1..15.

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
arid  input  4  read ID
araddr  input  32  read start address
arlen  input  8  beats-1
arsize  input  3  beat size (0..2)
arburst  input  2  00 FIXED, 01 INCR, 10 WRAP
arvalid  input  1  AR valid
arready  output  1  AR ready
rid  output  4  echo of accepted arid
rdata  output  32  read data, full word
rresp  output  2  read response
rlast  output  1  final read beat
rvalid  output  1  R valid
rready  input  1  R ready
awid  input  4  write ID
awaddr  input  32  write start address
awlen  input  8  beats-1
awsize  input  3  beat size
awburst  input  2  burst type
awvalid  input  1  AW valid
awready  output  1  AW ready
wid  input  4  write-data ID (ignored)
wdata  input  32  write data
wstrb  input  4  byte-lane enables
wlast  input  1  final write beat
wvalid  input  1  W valid
wready  output  1  W ready
bid  output  4  echo of accepted awid
bresp  output  2  write response
bvalid  output  1  B valid
bready  input  1  B ready
(arlock/arcache/arprot/awlock/awcache/awprot are not ports; the integrator leaves them unconnected.)

Behaviour:
- Reset (resetn low): read FSM is R_IDLE and write FSM is W_IDLE. All outputs are 0, including arready and awready. A registered "live" flag sets on the first clk edge after resetn rises. arready and awready are gated by this flag, so they first assert one cycle after release. Memory contents are not reset.
- Reset mid-burst: both FSMs abort immediately. No B or R completion is issued for the aborted transaction.
- Address stepping: INCR and WRAP (WRAP is treated as INCR) add 1 to the word index per beat. FIXED keeps the index. The index wraps modulo 2^MEM_AW. arsize/awsize do not change stepping. Narrow transfers return the full word; lane selection belongs to the master.
- Read FSM:
  - R_IDLE: arready = 1. On arvalid && arready, latch arid, the word index, arlen, and the burst type, and clear the beat counter. If READ_LATENCY = 1, go to R_DATA; otherwise go to R_WAIT.
  - R_WAIT: a down-counter runs READ_LATENCY-1 cycles, then the FSM goes to R_DATA.
  - R_DATA: rvalid = 1. rdata is a register loaded from memory on entry and on each accepted non-final beat. rdata, rid, and rlast stay stable while rvalid && !rready. rlast = (beat counter == latched len). rresp = 00. On rvalid && rready && rlast, go to R_IDLE; arready reasserts the next cycle, so there is no same-cycle re-accept.
  - Latency: the first rvalid arrives READ_LATENCY cycles after the AR handshake. Back-to-back beats have zero bubbles when rready is held high.
- Write FSM:
  - W_IDLE: awready = 1, wready = 0. On the AW handshake, latch awid, the index, awlen, and the burst type; clear the beat counter and the error flag; go to W_DATA.
  - W_DATA: wready = 1. On each W handshake, write each byte lane whose wstrb bit is 1 at the current index, then step the index and increment the counter.
    - wlast with counter == len: go to W_RESP with OKAY.
    - wlast with counter < len: set error and go to W_RESP.
    - counter == len without wlast: set error and go to W_RESP.
  - W_RESP: bvalid = 1, bid = latched awid, bresp = error ? 10 (SLVERR) : 00. On bready, go to W_IDLE.
  - W beats presented before the AW handshake are not accepted, because wready = 0 in W_IDLE.
- Simultaneous events:
  - Read and write channels operate fully concurrently.
  - A same-edge write and rdata load to the same word: rdata gets the pre-write value.
  - A write that commits before an rdata load is visible to that load.

Test Plan:
- Reset release: resetn low for 3 cycles, then high → all outputs stay 0 until 1 cycle after release, then arready = awready = 1.
- Single write then read: AW(id 3, addr 0x100, len 0), W(0xDEADBEEF, strb F, wlast) → bvalid with bid 3, bresp 00. Then AR(id 5, 0x100, len 0) → after 1 cycle, rvalid with rdata 0xDEADBEEF, rid 5, rlast 1.
- Byte strobe: write 0x11223344 to 0x200, then 0xAABBCCDD with strb 0101 → read returns 0x11BB33DD.
- INCR read burst with backpressure: preload 0x300..0x30C with 1,2,3,4; AR len 3 INCR; rready toggles 1/0 → beats 1,2,3,4 in order, data held while stalled, rlast only on beat 4. Repeat with FIXED → four beats of 1.
- Write protocol error: AW len 3, wlast asserted on beat 2 → bresp 10, only 2 words written. Also AW len 1 with no wlast → bresp 10 after beat 2.
- Concurrency and latency: READ_LATENCY = 4; issue AR and AW on the same cycle to different addresses → first rvalid exactly 4 cycles after the AR handshake, and B completes independently. Assert resetn low mid-read-burst → rvalid drops immediately and arready returns 1 cycle after release.
